pc_sequencer: RTL and testbench

Parametrised program sequencer: program counter, relative branch adder and return-address stack in one registered block. It is the next generation of the processor's fetch-address path, replacing the separate counter, jump adder, stack and PC-load mux. It adds configurable address width, offset width and stack depth, a stall enable, explicit call/return priority, and full/empty/overflow handling. It drives the instruction ROM address directly.

---
 rtl/seq_pkg.sv | 34 +++
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/seq_ras.sv | 120 ++++++++++++
 rtl/pc_sequencer.sv | 108 ++++++++++
 tb/tb_pc_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer: operation encoding,
// control priority resolution and sign extension of branch offsets.
package seq_pkg;

    typedef enum logic [1:0] {
        SEQ_NEXT   = 2'd0,
        SEQ_BRANCH = 2'd1,
        SEQ_CALL   = 2'd2,
        SEQ_RET    = 2'd3
    } seq_op_e;

    // Resolve raw controls to one operation: ret > call > taken branch > sequential.
    function automatic seq_op_e seq_resolve(input logic ret, input logic call,
                                            input logic cond, input logic zero);
        if (ret) begin
            return SEQ_RET;
        end
        if (call) begin
            return SEQ_CALL;
        end
        if (cond && zero) begin
            return SEQ_BRANCH;
        end
        return SEQ_NEXT;
    endfunction

    // Sign-extend the low w bits of val to 64 bits; callers truncate to their width.
    function automatic logic [63:0] seq_sext(input logic [63:0] val, input int unsigned w);
        logic [63:0] t;
        t = val << (64 - w);
        return 64'($signed(t) >>> (64 - w));
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the instruction decoder and the sequencer.
// err_clr/err exist only when SEQ_STACK_ERR_EN is defined.
interface pc_sequencer_if #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned OFF_W       = 8,
    parameter int unsigned STACK_DEPTH = 4
);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic               en;
    logic               cond;
    logic               zero;
    logic               call;
    logic               ret;
    logic [OFF_W-1:0]   offset;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  ret_addr;
    logic [DEPTH_W-1:0] depth;
    logic               full;
    logic               empty;
`ifdef SEQ_STACK_ERR_EN
    logic               err_clr;
    logic               err;

    modport master (output en, cond, zero, call, ret, offset, err_clr,
                    input  pc, ret_addr, depth, full, empty, err);
    modport slave  (input  en, cond, zero, call, ret, offset, err_clr,
                    output pc, ret_addr, depth, full, empty, err);
`else
    modport master (output en, cond, zero, call, ret, offset,
                    input  pc, ret_addr, depth, full, empty);
    modport slave  (input  en, cond, zero, call, ret, offset,
                    output pc, ret_addr, depth, full, empty);
`endif
endinterface

// File: rtl/seq_ras.sv
// Return-address stack: ring buffer plus write pointer and occupancy count.
// SEQ_STACK_ERR_EN defined: overflow/underflow are suppressed and flagged in a
// sticky err bit. Undefined: overflow overwrites the oldest entry, underflow is a no-op.
module seq_ras
    import seq_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  push,
    input  logic                                  pop,
    input  logic [ADDR_W-1:0]                     push_data,
`ifdef SEQ_STACK_ERR_EN
    input  logic                                  err_clr,
    output logic                                  err,
`endif
    output logic [ADDR_W-1:0]                     top,
    output logic [$clog2(STACK_DEPTH + 1)-1:0]    depth,
    output logic                                  full,
    output logic                                  empty
);
    localparam int unsigned PTR_W   = $clog2(STACK_DEPTH);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam logic [PTR_W-1:0]   LAST_SLOT = PTR_W'(STACK_DEPTH - 1);
    localparam logic [DEPTH_W-1:0] FULL_CNT  = DEPTH_W'(STACK_DEPTH);

    logic [ADDR_W-1:0]  mem_q [STACK_DEPTH];
    logic [ADDR_W-1:0]  mem_d [STACK_DEPTH];
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [DEPTH_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]  top_q, top_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
`ifdef SEQ_STACK_ERR_EN
    logic               err_q, err_d;
`endif

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] wrap_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? LAST_SLOT : p - PTR_W'(1);
    endfunction

    // Next stack state; ptr always names the next free (or, when full, oldest) slot.
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
`ifdef SEQ_STACK_ERR_EN
        err_d = err_q & ~err_clr;
`endif
        if (push) begin
            if (cnt_q == FULL_CNT) begin
`ifdef SEQ_STACK_ERR_EN
                err_d = 1'b1;
`else
                mem_d[ptr_q] = push_data;
                ptr_d        = wrap_inc(ptr_q);
`endif
            end else begin
                mem_d[ptr_q] = push_data;
                ptr_d        = wrap_inc(ptr_q);
                cnt_d        = cnt_q + DEPTH_W'(1);
            end
        end else if (pop) begin
            if (cnt_q != '0) begin
                ptr_d = wrap_dec(ptr_q);
                cnt_d = cnt_q - DEPTH_W'(1);
            end
`ifdef SEQ_STACK_ERR_EN
            else begin
                err_d = 1'b1;
            end
`endif
        end
        top_d   = (cnt_d == '0) ? '0 : mem_d[wrap_dec(ptr_d)];
        full_d  = (cnt_d == FULL_CNT);
        empty_d = (cnt_d == '0);
    end

    // Stack registers; reset clears every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            ptr_q   <= '0;
            cnt_q   <= '0;
            top_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
`ifdef SEQ_STACK_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            mem_q   <= mem_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            top_q   <= top_d;
            full_q  <= full_d;
            empty_q <= empty_d;
`ifdef SEQ_STACK_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign top   = top_q;
    assign depth = cnt_q;
    assign full  = full_q;
    assign empty = empty_q;
`ifdef SEQ_STACK_ERR_EN
    assign err   = err_q;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Program sequencer: PC register, relative branch adder and next-PC select in
// front of a return-address stack. Optional macro SEQ_STACK_ERR_EN selects a
// checked stack with sticky err/err_clr; otherwise the stack is circular.
module pc_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       OFF_W       = 8,
    parameter int unsigned       STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic         clk,
    input  logic         reset,
    pc_sequencer_if.slave bus
);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc_inc_c, pc_tgt_c, off_ext_c;
    logic [ADDR_W-1:0]  top_w;
    logic [DEPTH_W-1:0] depth_w;
    logic               full_w, empty_w;
    logic               push_c, pop_c;
    seq_op_e            op_c;

    // Operation select and next PC; en=0 holds everything.
    always_comb begin
        off_ext_c = ADDR_W'(seq_sext(64'(bus.offset), OFF_W));
        pc_inc_c  = pc_q + ADDR_W'(1);
        pc_tgt_c  = pc_q + off_ext_c;
        op_c      = seq_resolve(bus.ret, bus.call, bus.cond, bus.zero);
        pc_d      = pc_q;
        push_c    = 1'b0;
        pop_c     = 1'b0;
        if (bus.en) begin
            case (op_c)
                SEQ_NEXT:   pc_d = pc_inc_c;
                SEQ_BRANCH: pc_d = pc_tgt_c;
                SEQ_CALL: begin
                    push_c = 1'b1;
                    pc_d   = pc_tgt_c;
`ifdef SEQ_STACK_ERR_EN
                    if (full_w) begin
                        pc_d = pc_inc_c;
                    end
`endif
                end
                SEQ_RET: begin
                    pop_c = 1'b1;
                    if (empty_w) begin
`ifdef SEQ_STACK_ERR_EN
                        pc_d = pc_inc_c;
`else
                        pc_d = RESET_PC;
`endif
                    end else begin
                        pc_d = top_w;
                    end
                end
                default: pc_d = pc_inc_c;
            endcase
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef SEQ_STACK_ERR_EN
    logic clr_c;
    logic err_w;
    assign clr_c = bus.en & bus.err_clr;
`endif

    seq_ras #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .pop       (pop_c),
        .push_data (pc_inc_c),
`ifdef SEQ_STACK_ERR_EN
        .err_clr   (clr_c),
        .err       (err_w),
`endif
        .top       (top_w),
        .depth     (depth_w),
        .full      (full_w),
        .empty     (empty_w)
    );

    assign bus.pc       = pc_q;
    assign bus.ret_addr = top_w;
    assign bus.depth    = depth_w;
    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
`ifdef SEQ_STACK_ERR_EN
    assign bus.err      = err_w;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer: directed scenarios plus random traffic,
// expected state from a queue-based model of the PC and return stack.
module tb_pc_sequencer;
    localparam int unsigned AW  = 8;
    localparam int unsigned OW  = 8;
    localparam int unsigned SD  = 4;
    localparam int          RPC = 0;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(AW), .OFF_W(OW), .STACK_DEPTH(SD)) bus ();

    pc_sequencer #(
        .ADDR_W      (AW),
        .OFF_W       (OW),
        .STACK_DEPTH (SD),
        .RESET_PC    (8'h00)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int pc;
        int ra;
        int depth;
        int full;
        int empty;
        int err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    int   m_pc  = RPC;
    int   m_stack[$];
    int   m_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.pc    = m_pc;
        e.ra    = (m_stack.size() > 0) ? m_stack[$] : 0;
        e.depth = m_stack.size();
        e.full  = (m_stack.size() == int'(SD)) ? 1 : 0;
        e.empty = (m_stack.size() == 0) ? 1 : 0;
        e.err   = m_err;
        return e;
    endfunction

    // Reference behaviour of one clock edge, straight from the operation rules.
    task automatic model_step(input bit en, input bit cond, input bit zero, input bit call,
                              input bit ret, input int off, input bit clr);
        int soff;
        bit fault;
        soff  = (off >= 128) ? off - 256 : off;
        fault = 1'b0;
        if (!en) return;
        if (ret) begin
            if (m_stack.size() > 0) begin
                m_pc = m_stack.pop_back();
            end else begin
`ifdef SEQ_STACK_ERR_EN
                fault = 1'b1;
                m_pc  = (m_pc + 1) & 255;
`else
                m_pc  = RPC;
`endif
            end
        end else if (call) begin
            if (m_stack.size() == int'(SD)) begin
`ifdef SEQ_STACK_ERR_EN
                fault = 1'b1;
                m_pc  = (m_pc + 1) & 255;
`else
                void'(m_stack.pop_front());
                m_stack.push_back((m_pc + 1) & 255);
                m_pc = (m_pc + soff) & 255;
`endif
            end else begin
                m_stack.push_back((m_pc + 1) & 255);
                m_pc = (m_pc + soff) & 255;
            end
        end else if (cond && zero) begin
            m_pc = (m_pc + soff) & 255;
        end else begin
            m_pc = (m_pc + 1) & 255;
        end
`ifdef SEQ_STACK_ERR_EN
        m_err = ((m_err != 0 && !clr) || fault) ? 1 : 0;
`else
        m_err = (clr && fault) ? 1 : 0;
`endif
    endtask

    // Drive one cycle of controls and queue the state expected after the next edge.
    task automatic step(input bit en, input bit cond, input bit zero, input bit call,
                        input bit ret, input int off, input bit clr);
        @(negedge clk);
        bus.en     = en;
        bus.cond   = cond;
        bus.zero   = zero;
        bus.call   = call;
        bus.ret    = ret;
        bus.offset = 8'(off);
`ifdef SEQ_STACK_ERR_EN
        bus.err_clr = clr;
`endif
        model_step(en, cond, zero, call, ret, off, clr);
        sb.push_back(snapshot());
    endtask

    task automatic goto_pc(input int target);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, (target - m_pc) & 255, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pc"},       32'(bus.pc),       32'(RPC));
        chk({tag, "_depth"},    32'(bus.depth),    32'd0);
        chk({tag, "_empty"},    32'(bus.empty),    32'd1);
        chk({tag, "_full"},     32'(bus.full),     32'd0);
        chk({tag, "_ret_addr"}, 32'(bus.ret_addr), 32'd0);
`ifdef SEQ_STACK_ERR_EN
        chk({tag, "_err"},      32'(bus.err),      32'd0);
`endif
    endtask

    // Assert reset between edges and check that state clears without a clock edge.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        bus.en = 1'b0;
        reset  = 1'b0;
        #1;
        check_reset_state(tag);
        m_pc = RPC;
        m_stack.delete();
        m_err = 0;
        @(negedge clk);
        #2;
        reset = 1'b1;
    endtask

    // Monitor: compare queued expectations against the outputs after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc",       32'(bus.pc),       32'(e.pc));
                chk("ret_addr", 32'(bus.ret_addr), 32'(e.ra));
                chk("depth",    32'(bus.depth),    32'(e.depth));
                chk("full",     32'(bus.full),     32'(e.full));
                chk("empty",    32'(bus.empty),    32'(e.empty));
`ifdef SEQ_STACK_ERR_EN
                chk("err",      32'(bus.err),      32'(e.err));
`endif
            end
        end
    end

    initial begin
        reset      = 1'b1;
        bus.en     = 1'b0;
        bus.cond   = 1'b0;
        bus.zero   = 1'b0;
        bus.call   = 1'b0;
        bus.ret    = 1'b0;
        bus.offset = '0;
`ifdef SEQ_STACK_ERR_EN
        bus.err_clr = 1'b0;
`endif
        #2;
        reset = 1'b0;
        #10;
        check_reset_state("init");
        @(negedge clk);
        #2;
        reset = 1'b1;

        // Held with en=0, then sequential count and wrap.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        goto_pc(8'hFF);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Taken and not-taken branch.
        goto_pc(8'h10);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFC, 1'b0);
        goto_pc(8'h10);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFC, 1'b0);

        // Call then return.
        goto_pc(8'h20);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);

        // Five nested calls, error clear, then unwind past empty.
        do_reset("rst_ovf");
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);

        // Call/ret contention, and the same request blocked by en=0.
        do_reset("rst_cont");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 1'b1);

        // Reset with a live stack, then hold after release.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0);
        do_reset("rst_mid");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 7));
            step(($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 (r == 2 || r == 3 || r == 4),
                 (r == 0 || r == 1 || r == 4),
                 int'($urandom_range(0, 255)),
                 ($urandom_range(0, 7) == 0));
        end

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d expected=0 pending entries", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
